// File: rtl/alu_sequencer.sv
// Register file and four-state operation sequencer that feeds an external 8-bit ALU.
// Operands are registered into the ALU inputs, then the ALU result and flags are captured one cycle later.
module alu_sequencer #(
  parameter int NREGS   = 8,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [2:0] req_src_a,
  input  logic [2:0] req_src_b,
  input  logic [2:0] req_dst,
  input  logic       ld_valid,
  input  logic [2:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic [7:0] alu_in_A,
  output logic [7:0] alu_in_B,
  output logic [2:0] alu_op,
  output logic       alu_enable_out,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flags,
  output logic [3:0] flags_q,
  output logic       done,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam logic [2:0] OP_COMP = 3'b101;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] rf [NREGS];
  logic [2:0] op_q;
  logic [2:0] src_a_q;
  logic [2:0] src_b_q;
  logic [2:0] dst_q;
  logic       wb_en;

  // r0 is hard-wired to zero when ZERO_R0 is set; addresses past NREGS hold nothing.
  function automatic logic live_reg(input logic [2:0] addr);
    return !(ZERO_R0 && addr == 3'd0) && (int'(addr) < NREGS);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = FETCH;
      FETCH:   state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state == IDLE);
    alu_enable_out = (state == EXEC);
    done           = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      alu_in_A <= '0;
      alu_in_B <= '0;
      alu_op   <= '0;
      flags_q  <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        op_q    <= req_op;
        src_a_q <= req_src_a;
        src_b_q <= req_src_b;
        dst_q   <= req_dst;
      end
      if (state == FETCH) begin
        alu_in_A <= live_reg(src_a_q) ? rf[src_a_q] : 8'h00;
        alu_in_B <= live_reg(src_b_q) ? rf[src_b_q] : 8'h00;
        alu_op   <= op_q;
      end
      if (state == EXEC) flags_q <= alu_flags;
    end
  end

  assign wb_en = (state == EXEC) && (op_q != OP_COMP) && live_reg(dst_q);

  // The writeback assignment comes last so it wins over a same-edge load to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      if (ld_valid && live_reg(ld_addr)) rf[ld_addr] <= ld_data;
      if (wb_en) rf[dst_q] <= alu_out;
    end
  end

  assign dbg_data = live_reg(dbg_addr) ? rf[dbg_addr] : 8'h00;

endmodule
